// File: rtl/adc_spi_target_model_if.sv
// 3-wire SPI pin bundle between an ADC configuration initiator
// and the target model (SEN/SCLK/RESET/SDIO with split SDIO drive).
interface adc_spi_target_model_if;
    logic spi_sen_i;
    logic spi_clk_i;
    logic spi_reset_i;
    logic spi_sdio_i;
    logic spi_sdio_o;
    logic spi_sdio_oe;

    modport master (
        output spi_sen_i,
        output spi_clk_i,
        output spi_reset_i,
        output spi_sdio_i,
        input  spi_sdio_o,
        input  spi_sdio_oe
    );

    modport slave (
        input  spi_sen_i,
        input  spi_clk_i,
        input  spi_reset_i,
        input  spi_sdio_i,
        output spi_sdio_o,
        output spi_sdio_oe
    );
endinterface

// File: rtl/adc_spi_target_model.sv
// Oversampled 3-wire SPI target with a small register file,
// answering 24-bit R/W/addr/data configuration frames.
module adc_spi_target_model #(
    parameter int          NUM_REGS = 16,
    parameter logic [7:0]  RST_VAL  = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    adc_spi_target_model_if.slave  spi,
    output logic                   wr_pulse,
    output logic [11:0]            wr_addr,
    output logic [7:0]             wr_data,
    output logic [NUM_REGS*8-1:0]  regs_flat,
    output logic [7:0]             frame_err_cnt
);

    localparam logic [11:0] NREG = 12'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WDAT,
        S_RDAT,
        S_WAIT
    } state_t;

    state_t                r_state;
    logic [1:0]            r_sen_s;
    logic [1:0]            r_clk_s;
    logic [1:0]            r_sdio_s;
    logic [1:0]            r_rst_s;
    logic                  r_clk_d;
    logic                  r_rst_q;
    logic [14:0]           r_sh;
    logic [4:0]            r_cnt;
    logic [11:0]           r_addr;
    logic                  r_hit;
    logic [7:0]            r_rd;
    logic                  r_oe;
    logic                  r_pend;
    logic [11:0]           r_paddr;
    logic [7:0]            r_pdata;
    logic                  r_wr_pulse;
    logic [11:0]           r_wr_addr;
    logic [7:0]            r_wr_data;
    logic [7:0]            r_err;
    logic [NUM_REGS*8-1:0] r_regs;

    logic        w_sen;
    logic        w_rise;
    logic        w_fall;
    logic        w_hrst;
    logic        w_abort;
    logic [15:0] w_sh_nx;
    logic [11:0] w_addr;
    logic [7:0]  w_rd_val;
    logic        w_unused;

    assign w_sen   = r_sen_s[1];
    assign w_rise  = r_clk_s[1] & ~r_clk_d;
    assign w_fall  = ~r_clk_s[1] & r_clk_d;
    // Hard reset must be seen on two consecutive synchronized samples
    assign w_hrst  = r_rst_s[1] & r_rst_q;
    assign w_sh_nx = {r_sh, r_sdio_s[1]};
    assign w_addr  = w_sh_nx[11:0];
    assign w_abort = w_sen & ((r_state == S_HDR) |
                              (r_state == S_WDAT) |
                              (r_state == S_RDAT));
    assign w_unused = ^w_sh_nx[14:12];

    always_comb begin
        w_rd_val = 8'h00;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_addr == 12'(k)) w_rd_val = r_regs[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sen_s    <= 2'b11;
            r_clk_s    <= 2'b00;
            r_sdio_s   <= 2'b00;
            r_rst_s    <= 2'b00;
            r_clk_d    <= 1'b0;
            r_rst_q    <= 1'b0;
            r_sh       <= '0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_hit      <= 1'b0;
            r_rd       <= '0;
            r_oe       <= 1'b0;
            r_pend     <= 1'b0;
            r_paddr    <= '0;
            r_pdata    <= '0;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_err      <= '0;
            r_regs     <= {NUM_REGS{RST_VAL}};
        end else begin
            r_sen_s    <= {r_sen_s[0], spi.spi_sen_i};
            r_clk_s    <= {r_clk_s[0], spi.spi_clk_i};
            r_sdio_s   <= {r_sdio_s[0], spi.spi_sdio_i};
            r_rst_s    <= {r_rst_s[0], spi.spi_reset_i};
            r_clk_d    <= r_clk_s[1];
            r_rst_q    <= r_rst_s[1];
            r_wr_pulse <= 1'b0;
            if (w_hrst) begin
                r_regs  <= {NUM_REGS{RST_VAL}};
                r_state <= S_IDLE;
                r_oe    <= 1'b0;
                r_rd    <= '0;
                r_pend  <= 1'b0;
            end else begin
                if (r_pend) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (r_paddr == 12'(k)) r_regs[8*k +: 8] <= r_pdata;
                    end
                    r_wr_addr  <= r_paddr;
                    r_wr_data  <= r_pdata;
                    r_wr_pulse <= 1'b1;
                    r_pend     <= 1'b0;
                end
                if (w_abort) begin
                    r_state <= S_IDLE;
                    r_oe    <= 1'b0;
                    if (r_err != 8'hFF) r_err <= r_err + 8'd1;
                end else begin
                    unique case (r_state)
                        S_IDLE: begin
                            if (!w_sen) begin
                                r_cnt   <= '0;
                                r_state <= S_HDR;
                            end
                        end
                        S_HDR: begin
                            if (w_rise) begin
                                r_sh  <= w_sh_nx[14:0];
                                r_cnt <= r_cnt + 5'd1;
                                if (r_cnt == 5'd15) begin
                                    r_addr <= w_addr;
                                    r_hit  <= (w_addr < NREG);
                                    if (w_sh_nx[15]) begin
                                        r_rd    <= w_rd_val;
                                        r_oe    <= 1'b1;
                                        r_state <= S_RDAT;
                                    end else begin
                                        r_state <= S_WDAT;
                                    end
                                end
                            end
                        end
                        S_WDAT: begin
                            if (w_rise) begin
                                r_sh  <= w_sh_nx[14:0];
                                r_cnt <= r_cnt + 5'd1;
                                if (r_cnt == 5'd23) begin
                                    r_pend  <= r_hit;
                                    r_paddr <= r_addr;
                                    r_pdata <= w_sh_nx[7:0];
                                    r_state <= S_WAIT;
                                end
                            end
                        end
                        S_RDAT: begin
                            if (w_rise) begin
                                r_cnt <= r_cnt + 5'd1;
                                if (r_cnt == 5'd23) r_state <= S_WAIT;
                            // Bit 7 must hold through the 17th rise
                            end else if (w_fall && r_cnt > 5'd16) begin
                                r_rd <= {r_rd[6:0], 1'b0};
                            end
                        end
                        S_WAIT: begin
                            if (w_sen) begin
                                r_state <= S_IDLE;
                                r_oe    <= 1'b0;
                            end else if (w_fall) begin
                                r_oe <= 1'b0;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign spi.spi_sdio_o  = r_rd[7];
    assign spi.spi_sdio_oe = r_oe;
    assign wr_pulse        = r_wr_pulse;
    assign wr_addr         = r_wr_addr;
    assign wr_data         = r_wr_data;
    assign regs_flat       = r_regs;
    assign frame_err_cnt   = r_err;

endmodule

// File: tb/tb_adc_spi_target_model.sv
// Directed plus randomized frames against an array model of the
// target's register file, error counter and write strobes.
module tb_adc_spi_target_model;
    localparam int N = 16;
    localparam int H = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wr_pulse;
    logic [11:0]    wr_addr;
    logic [7:0]     wr_data;
    logic [N*8-1:0] regs_flat;
    logic [7:0]     frame_err_cnt;

    adc_spi_target_model_if spi ();

    adc_spi_target_model #(.NUM_REGS(N), .RST_VAL(8'h00)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spi           (spi),
        .wr_pulse      (wr_pulse),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .regs_flat     (regs_flat),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always @(posedge clk) if (wr_pulse === 1'b1) pulses++;

    logic [7:0]  mdl [N];
    int          m_err;
    int          m_pulses;
    logic [11:0] m_wa;
    logic [7:0]  m_wd;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mflat();
        logic [127:0] f;
        f = '0;
        for (int k = 0; k < N; k++) f[8*k +: 8] = mdl[k];
        return f;
    endfunction

    task automatic hc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_write(input int a, input logic [7:0] d);
        if (a < N) begin
            mdl[a]   = d;
            m_pulses = m_pulses + 1;
            m_wa     = 12'(a);
            m_wd     = d;
        end
    endtask

    task automatic m_abort();
        if (m_err < 255) m_err = m_err + 1;
    endtask

    // nb: bits clocked before SEN rises; rs_at: spi_reset pulse before
    // that bit; rn_at: rst_n asserted before that bit (frame abandoned)
    task automatic xfer(input bit rw, input logic [11:0] a,
                        input logic [7:0] d, input int nb,
                        input int rs_at, input int rn_at,
                        output logic [7:0] rd, output bit oe_bad);
        logic [23:0] f;
        f = {rw, 3'b101, a, d};
        rd = '0;
        oe_bad = 1'b0;
        spi.spi_sen_i = 1'b0;
        hc(H);
        for (int i = 0; i < nb; i++) begin
            if (i == rn_at) begin
                rst_n = 1'b0;
                return;
            end
            if (i == rs_at) begin
                spi.spi_reset_i = 1'b1;
                hc(4);
                spi.spi_reset_i = 1'b0;
            end
            spi.spi_sdio_i = (rw && i >= 16) ? 1'b0 : f[23-i];
            hc(H);
            if (rw) begin
                if (i >= 16) rd[23-i] = spi.spi_sdio_o;
                if (spi.spi_sdio_oe !== (i >= 16)) oe_bad = 1'b1;
            end else if (spi.spi_sdio_oe !== 1'b0) begin
                oe_bad = 1'b1;
            end
            spi.spi_clk_i = 1'b1;
            hc(H);
            spi.spi_clk_i = 1'b0;
        end
        hc(H);
        if (spi.spi_sdio_oe !== 1'b0) oe_bad = 1'b1;
        spi.spi_sen_i = 1'b1;
        hc(4);
    endtask

    initial begin
        logic [7:0]  rd;
        bit          ob;
        int          a;
        logic [7:0]  d;
        int          p0;
        logic [11:0] wa0;
        logic [7:0]  wd0;

        for (int k = 0; k < N; k++) mdl[k] = 8'h00;
        m_err = 0;
        m_pulses = 0;
        m_wa = '0;
        m_wd = '0;
        rst_n = 1'b0;
        spi.spi_sen_i = 1'b1;
        spi.spi_clk_i = 1'b0;
        spi.spi_reset_i = 1'b0;
        spi.spi_sdio_i = 1'b0;
        hc(3);
        chk("rst_oe", spi.spi_sdio_oe, 1'b0);
        chk("rst_sdo", spi.spi_sdio_o, 1'b0);
        chk("rst_pulse", wr_pulse, 1'b0);
        chk("rst_waddr", wr_addr, 12'h000);
        chk("rst_wdata", wr_data, 8'h00);
        chk("rst_err", frame_err_cnt, 8'h00);
        chk("rst_regs", regs_flat, mflat());
        rst_n = 1'b1;
        hc(3);

        xfer(1'b0, 12'h003, 8'hA5, 24, -1, -1, rd, ob);
        m_write(3, 8'hA5);
        chk("w3_oe", ob, 1'b0);
        chk("w3_pulses", pulses, m_pulses);
        chk("w3_waddr", wr_addr, 12'h003);
        chk("w3_wdata", wr_data, 8'hA5);
        chk("w3_reg", regs_flat[31:24], 8'hA5);
        xfer(1'b1, 12'h003, 8'h00, 24, -1, -1, rd, ob);
        chk("r3_data", rd, 8'hA5);
        chk("r3_oe", ob, 1'b0);

        xfer(1'b0, 12'h0FF, 8'h3C, 24, -1, -1, rd, ob);
        chk("wff_pulses", pulses, m_pulses);
        chk("wff_regs", regs_flat, mflat());
        xfer(1'b1, 12'h0FF, 8'h00, 24, -1, -1, rd, ob);
        chk("rff_data", rd, 8'h00);
        chk("rff_oe", ob, 1'b0);

        xfer(1'b0, 12'h001, 8'h77, 12, -1, -1, rd, ob);
        m_abort();
        chk("ab_regs", regs_flat, mflat());
        chk("ab_err", frame_err_cnt, m_err);
        chk("ab_pulses", pulses, m_pulses);

        xfer(1'b0, 12'h000, 8'h11, 24, -1, -1, rd, ob);
        m_write(0, 8'h11);
        xfer(1'b0, 12'h00F, 8'hFF, 24, -1, -1, rd, ob);
        m_write(15, 8'hFF);
        xfer(1'b1, 12'h000, 8'h00, 24, -1, -1, rd, ob);
        chk("b2b_rd", rd, 8'h11);
        chk("b2b_regs", regs_flat, mflat());
        chk("b2b_pulses", pulses, m_pulses);

        for (int t = 0; t < 24; t++) begin
            a = $urandom_range(0, N + 3);
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                xfer(1'b0, 12'(a), d, 24, -1, -1, rd, ob);
                m_write(a, d);
            end else begin
                xfer(1'b1, 12'(a), d, 24, -1, -1, rd, ob);
                chk("rnd_rd", rd, (a < N) ? mdl[a] : 8'h00);
                chk("rnd_oe", ob, 1'b0);
            end
        end
        chk("rnd_regs", regs_flat, mflat());
        chk("rnd_pulses", pulses, m_pulses);
        chk("rnd_waddr", wr_addr, m_wa);
        chk("rnd_wdata", wr_data, m_wd);

        for (int t = 0; t < 300; t++) begin
            xfer(1'(t & 1), 12'($urandom_range(0, 15)), 8'h5A,
                 $urandom_range(1, 23), -1, -1, rd, ob);
            m_abort();
            if (t == 100) chk("ab100_err", frame_err_cnt, m_err);
        end
        chk("ab300_err", frame_err_cnt, m_err);
        chk("ab300_regs", regs_flat, mflat());

        xfer(1'b0, 12'h002, 8'h5A, 24, -1, -1, rd, ob);
        m_write(2, 8'h5A);
        chk("w2_reg", regs_flat[23:16], 8'h5A);
        spi.spi_reset_i = 1'b1;
        hc(4);
        spi.spi_reset_i = 1'b0;
        hc(4);
        for (int k = 0; k < N; k++) mdl[k] = 8'h00;
        chk("hrst_regs", regs_flat, mflat());
        chk("hrst_err", frame_err_cnt, m_err);

        p0  = pulses;
        wa0 = wr_addr;
        wd0 = wr_data;
        xfer(1'b0, 12'h002, 8'h5A, 24, 10, -1, rd, ob);
        m_abort();
        chk("hmid_regs", regs_flat, mflat());
        chk("hmid_pulses", pulses, p0);
        chk("hmid_waddr", wr_addr, wa0);
        chk("hmid_wdata", wr_data, wd0);

        xfer(1'b0, 12'h000, 8'h99, 24, -1, -1, rd, ob);
        m_write(0, 8'h99);
        chk("w0_reg", regs_flat[7:0], 8'h99);
        xfer(1'b1, 12'h000, 8'h00, 24, -1, 19, rd, ob);
        #1;
        for (int k = 0; k < N; k++) mdl[k] = 8'h00;
        m_err = 0;
        chk("rn_oe", spi.spi_sdio_oe, 1'b0);
        chk("rn_sdo", spi.spi_sdio_o, 1'b0);
        chk("rn_pulse", wr_pulse, 1'b0);
        chk("rn_waddr", wr_addr, 12'h000);
        chk("rn_wdata", wr_data, 8'h00);
        chk("rn_err", frame_err_cnt, m_err);
        chk("rn_regs", regs_flat, mflat());
        spi.spi_sen_i = 1'b1;
        spi.spi_clk_i = 1'b0;
        hc(3);
        rst_n = 1'b1;
        hc(3);
        xfer(1'b1, 12'h000, 8'h00, 24, -1, -1, rd, ob);
        chk("rn_rd0", rd, 8'h00);
        chk("rn_rd_oe", ob, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
